inst_fetch: RTL and testbench

- Front-end stage directly upstream of the instruction decoder.
- Holds the PC and issues word-aligned requests to instruction memory.
- Buffers returned instructions, each with its PC, in an in-order ring buffer.
- Presents one {pc, instruction} pair per cycle to the decoder over a valid/ready handshake; a taken branch/jump redirect flushes all fetched and in-flight instructions.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_buffer.sv | 101 ++++++++++
 rtl/inst_fetch.sv | 137 +++++++++++++
 tb/tb_inst_fetch.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   XLEN          - datapath / address width
//   NOP_INST      - instruction presented to the decoder when nothing is valid
//   fetch_entry_t - one ring-buffer slot {pc, inst, filled}
//   fetch_pair_t  - {pc, inst} pair handed to the decoder
package fetch_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
      logic            filled;
   } fetch_entry_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_pair_t;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: in-order ring buffer of fetched instructions.
// An entry is allocated (pc written) when its request is issued, filled
// (inst written) when the response returns, and popped from the head.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   i_flush         - drop all entries and rewind every pointer
//   i_alloc_en/pc   - allocate the tail entry with this pc
//   i_fill_en/inst  - fill the oldest unfilled entry with this word
//   i_pop_en        - consume the head entry (ignored if head not valid)
//   o_head_valid    - head entry allocated and filled
//   o_head          - head {pc, inst}; {0, NOP} when not valid
//   o_alloc_cnt     - number of allocated entries
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic             i_alloc_en,
   input  logic [XLEN-1:0]  i_alloc_pc,
   input  logic             i_fill_en,
   input  logic [XLEN-1:0]  i_fill_inst,
   input  logic             i_pop_en,
   output logic             o_head_valid,
   output fetch_pair_t      o_head,
   output logic [CNT_W-1:0] o_alloc_cnt
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   fetch_entry_t     r_entries [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [PTR_W-1:0] r_fill;
   logic [CNT_W-1:0] r_cnt;
   logic             w_head_valid;
   logic             w_pop;

   // Empty buffer leaves head==tail on a possibly stale slot, so gate on count.
   assign w_head_valid = (r_cnt != '0) && r_entries[r_head].filled;
   assign w_pop        = i_pop_en && w_head_valid;

   // Pointer, count and entry storage update.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head <= '0;
         r_tail <= '0;
         r_fill <= '0;
         r_cnt  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_entries[i] <= '0;
         end
      end else if (i_flush) begin
         r_head <= '0;
         r_tail <= '0;
         r_fill <= '0;
         r_cnt  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_entries[i].filled <= 1'b0;
         end
      end else begin
         if (i_alloc_en) begin
            r_entries[r_tail].pc     <= i_alloc_pc;
            r_entries[r_tail].inst   <= NOP_INST;
            r_entries[r_tail].filled <= 1'b0;
            r_tail                   <= r_tail + PTR_W'(1);
         end
         if (i_fill_en) begin
            r_entries[r_fill].inst   <= i_fill_inst;
            r_entries[r_fill].filled <= 1'b1;
            r_fill                   <= r_fill + PTR_W'(1);
         end
         if (w_pop) begin
            r_head <= r_head + PTR_W'(1);
         end
         // Simultaneous alloc and pop leave the count unchanged.
         case ({i_alloc_en, w_pop})
            2'b10:   r_cnt <= r_cnt + CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Head presentation: defaults when nothing valid.
   always_comb begin
      o_head.pc   = '0;
      o_head.inst = NOP_INST;
      if (w_head_valid) begin
         o_head.pc   = r_entries[r_head].pc;
         o_head.inst = r_entries[r_head].inst;
      end
   end

   assign o_head_valid = w_head_valid;
   assign o_alloc_cnt  = r_cnt;

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: front-end fetch stage feeding the instruction decoder.
// Holds the PC, issues word-aligned requests to instruction memory, buffers
// in-order responses with their PCs and hands {pc, inst} pairs to the decoder.
// A redirect flushes the buffer; responses still in flight are counted and
// discarded before fetch resumes at the new PC.
// Optional feature macro: INST_FETCH_PERF_CNT_EN adds perf_fetched (decoder
// handshakes) and perf_dropped (discarded responses) counters.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   imem_req_valid/ready/addr     - request channel to instruction memory
//   imem_resp_valid/data          - in-order response channel
//   redirect_valid/pc             - taken branch/jump from execute
//   inst_valid/ready, inst_out, pc_out - decoder handshake and payload
module inst_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned BUF_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
`ifdef INST_FETCH_PERF_CNT_EN
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_dropped,
`endif
   output logic [31:0] inst_out,
   output logic [31:0] pc_out
);

   localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

   logic [XLEN-1:0]  r_pc;
   logic [CNT_W-1:0] r_outstanding;
   logic [CNT_W-1:0] r_drop_cnt;

   logic             w_req_fire;
   logic             w_resp_owed;
   logic             w_fill;
   logic             w_pop;
   logic             w_head_valid;
   fetch_pair_t      w_head;
   logic [CNT_W-1:0] w_alloc_cnt;

   // A response is owed only if something is outstanding or pending drop.
   assign w_resp_owed = imem_resp_valid && ((r_drop_cnt != '0) || (r_outstanding != '0));
   assign w_fill      = imem_resp_valid && !redirect_valid && (r_drop_cnt == '0)
                        && (r_outstanding != '0);
   assign w_pop       = w_head_valid && inst_ready && !redirect_valid;

   assign imem_req_valid = !rst && !redirect_valid && (w_alloc_cnt < CNT_W'(BUF_DEPTH))
                           && (r_drop_cnt == '0);
   assign imem_req_addr  = r_pc;
   assign w_req_fire     = imem_req_valid && imem_req_ready;

   fetch_buffer #(
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk          (clk),
      .rst          (rst),
      .i_flush      (redirect_valid),
      .i_alloc_en   (w_req_fire),
      .i_alloc_pc   (r_pc),
      .i_fill_en    (w_fill),
      .i_fill_inst  (imem_resp_data),
      .i_pop_en     (w_pop),
      .o_head_valid (w_head_valid),
      .o_head       (w_head),
      .o_alloc_cnt  (w_alloc_cnt)
   );

   assign inst_valid = w_head_valid;
   assign inst_out   = w_head.inst;
   assign pc_out     = w_head.pc;

   // PC, in-flight and drop accounting.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc          <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
      end else if (redirect_valid) begin
         // Drop count never overflows: issue is blocked while it is non-zero,
         // so outstanding is zero whenever drop_cnt is.
         r_pc          <= {redirect_pc[31:2], 2'b00};
         r_outstanding <= '0;
         r_drop_cnt    <= r_drop_cnt + r_outstanding - CNT_W'(w_resp_owed);
      end else begin
         if (w_req_fire) begin
            r_pc <= r_pc + 32'd4;
         end
         if (imem_resp_valid && (r_drop_cnt != '0)) begin
            r_drop_cnt <= r_drop_cnt - CNT_W'(1);
         end
         case ({w_req_fire, w_fill})
            2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
            2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

`ifdef INST_FETCH_PERF_CNT_EN
   logic [31:0] r_perf_fetched;
   logic [31:0] r_perf_dropped;
   logic        w_dropped;

   // Discarded: any owed response in a redirect cycle, else one eaten by drop_cnt.
   assign w_dropped = redirect_valid ? w_resp_owed : (imem_resp_valid && (r_drop_cnt != '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_fetched <= '0;
         r_perf_dropped <= '0;
      end else begin
         r_perf_fetched <= r_perf_fetched + 32'(w_pop);
         r_perf_dropped <= r_perf_dropped + 32'(w_dropped);
      end
   end

   assign perf_fetched = r_perf_fetched;
   assign perf_dropped = r_perf_dropped;
`endif

   // Memory must never answer a request that was not issued.
   a_resp_expected: assert property (@(posedge clk) disable iff (rst)
      imem_resp_valid |-> ((r_drop_cnt != '0) || (r_outstanding != '0)));

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: randomized + directed bench for inst_fetch against a
// queue-based reference model and an in-order instruction memory model.
module tb_inst_fetch;
   import fetch_pkg::*;

   localparam logic [31:0] RPC   = 32'h0000_0100;
   localparam int          DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_out;
   logic [31:0] pc_out;
`ifdef INST_FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_dropped;
`endif

   inst_fetch #(
      .RESET_PC  (RPC),
      .BUF_DEPTH (DEPTH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
`ifdef INST_FETCH_PERF_CNT_EN
      .perf_fetched    (perf_fetched),
      .perf_dropped    (perf_dropped),
`endif
      .inst_out        (inst_out),
      .pc_out          (pc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Instruction memory: in-order responses, each due `lat` cycles after accept.
   typedef struct {
      int          due;
      logic [31:0] data;
   } mresp_t;
   mresp_t mem_q[$];
   int     lat = 1;

   // Reference model: allocated pcs and returned words, both in program order.
   logic [31:0] m_pc;
   logic [31:0] m_q[$];
   logic [31:0] m_d[$];
   int          m_drop;
   int unsigned m_fetched;
   int unsigned m_dropped;
   bit          m_known = 1'b0;
   int          cyc = 0;

   logic [31:0] acc_log[$];
   logic [31:0] pop_log[$];
   int          pop_cyc[$];

   // One clock cycle: drive inputs, compare outputs to the model, advance the model.
   task automatic step(input bit rst_v, input bit rdy, input bit iready,
                       input bit redir, input logic [31:0] rpc, input bit allow_resp);
      bit     exp_rv;
      bit     exp_iv;
      bit     fire;
      bit     live;
      mresp_t t;
      @(negedge clk);
      rst            = rst_v;
      imem_req_ready = rdy;
      inst_ready     = iready;
      redirect_valid = redir;
      redirect_pc    = rpc;
      if (!rst_v && allow_resp && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mem_q[0].data;
         void'(mem_q.pop_front());
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = $urandom;
      end
      #1;
      exp_rv = !rst_v && !redir && (m_q.size() < DEPTH) && (m_drop == 0);
      chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (m_known) begin
         exp_iv = m_d.size() > 0;
         chk("inst_valid", 32'(inst_valid), 32'(exp_iv));
         chk("inst_out", inst_out, exp_iv ? m_d[0] : NOP_INST);
         chk("pc_out", pc_out, exp_iv ? m_q[0] : 32'h0);
         if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
         if (inst_valid) chk("inst_matches_pc", inst_out, mem_word(pc_out));
`ifdef INST_FETCH_PERF_CNT_EN
         chk("perf_fetched", perf_fetched, m_fetched);
         chk("perf_dropped", perf_dropped, m_dropped);
`endif
      end
      fire = exp_rv && rdy;
      if (rst_v) begin
         m_q.delete();
         m_d.delete();
         mem_q.delete();
         m_pc      = RPC;
         m_drop    = 0;
         m_fetched = 0;
         m_dropped = 0;
         m_known   = 1'b1;
         cyc       = -1;
      end else begin
         if (fire) begin
            t.due  = cyc + lat;
            t.data = mem_word(m_pc);
            mem_q.push_back(t);
            acc_log.push_back(m_pc);
         end
         if (redir) begin
            live   = imem_resp_valid && (m_drop > 0 || m_q.size() > m_d.size());
            m_drop = m_drop + (m_q.size() - m_d.size()) - (live ? 1 : 0);
            if (live) m_dropped++;
            m_q.delete();
            m_d.delete();
            m_pc = {rpc[31:2], 2'b00};
         end else begin
            if (m_d.size() > 0 && iready) begin
               pop_log.push_back(m_q[0]);
               pop_cyc.push_back(cyc);
               void'(m_q.pop_front());
               void'(m_d.pop_front());
               m_fetched++;
            end
            if (imem_resp_valid) begin
               if (m_drop > 0) begin
                  m_drop--;
                  m_dropped++;
               end else if (m_q.size() > m_d.size()) begin
                  m_d.push_back(imem_resp_data);
               end
            end
            if (fire) begin
               m_q.push_back(m_pc);
               m_pc = m_pc + 32'd4;
            end
         end
      end
      cyc++;
   endtask

   task automatic do_reset();
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      acc_log.delete();
      pop_log.delete();
      pop_cyc.delete();
   endtask

   initial begin
      int idx;
      rst = 1'b1; imem_req_ready = 1'b0; inst_ready = 1'b0;
      imem_resp_valid = 1'b0; imem_resp_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0;

      // Streaming with 1-cycle memory.
      lat = 1;
      do_reset();
      chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
      repeat (6) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("t1_req0", acc_log[0], 32'h100);
      chk("t1_req1", acc_log[1], 32'h104);
      chk("t1_req2", acc_log[2], 32'h108);
      chk("t1_pop0", pop_log[0], 32'h100);
      chk("t1_pop1", pop_log[1], 32'h104);
      chk("t1_pop2", pop_log[2], 32'h108);
      chk("t1_popcyc0", 32'(pop_cyc[0]), 32'd2);
      chk("t1_popcyc2", 32'(pop_cyc[2]), 32'd4);

      // Decoder stalled: buffer fills, issue stops.
      do_reset();
      repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("t2_accepted", 32'(acc_log.size()), 32'd4);
      chk("t2_held_inst", inst_out, mem_word(32'h100));
      chk("t2_req_blocked", 32'(imem_req_valid), 32'h0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("t2_resume", 32'(acc_log.size()), 32'd5);

      // Redirect with three requests in flight on 3-cycle memory.
      lat = 3;
      do_reset();
      repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 1'b1);
      repeat (10) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("t3_dropped", m_dropped, 32'd3);
      chk("t3_next_req", acc_log[3], 32'h200);
      chk("t3_first_pop", pop_log[0], 32'h200);

      // Unaligned redirect target.
      idx = acc_log.size();
      step(1'b0, 1'b1, 1'b1, 1'b1, 32'h203, 1'b1);
      repeat (10) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("t4_aligned_req", acc_log[idx], 32'h200);

      // Redirect coinciding with a pop and a response.
      lat = 1;
      do_reset();
      repeat (4) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 1'b1);
      chk("t5_pop_offered", 32'(inst_valid), 32'h1);
      chk("t5_resp_same", 32'(imem_resp_valid), 32'h1);
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("t5_empty", 32'(inst_valid), 32'h0);
      chk("t5_dropped", m_dropped, 32'd1);
      chk("t5_drop_cnt", 32'(m_drop), 32'd0);
      chk("t5_fetched", m_fetched, 32'd2);

      // Reset mid-stream with two filled entries.
      do_reset();
      repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("t6_filled", 32'(inst_valid), 32'h1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("t6_inst_valid", 32'(inst_valid), 32'h0);
      chk("t6_restart_pc", imem_req_addr, RPC);

      // Randomized traffic.
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         if (n % 500 == 0) lat = 1 + int'($urandom_range(0, 3));
         step(($urandom % 400) == 0,
              ($urandom % 4) != 0,
              ($urandom % 3) != 0,
              ($urandom % 25) == 0,
              $urandom,
              ($urandom % 4) != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
